bcd_to_binary_avalon: RTL and testbench

- Avalon-MM slave that accepts a packed BCD value on a write and converts it to binary.
- Uses a sequential reverse double-dabble: shift right, then subtract 3 from any BCD digit that is 8 or more.
- Result and status are readable over the same slave port.
- Inverse companion to the binary-to-BCD display path: it turns user-entered decimal digits (keypad or switches, written by the CPU) back into a binary operand.

---
 rtl/bcd_to_binary_avalon.sv | 164 ++++++++++++++++
 tb/tb_bcd_to_binary_avalon.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_avalon.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_avalon
//
// Avalon-MM slave that turns a packed BCD value (written by the CPU, e.g.
// keypad or switch digits) into a binary operand using a sequential reverse
// double-dabble: each cycle the {bcd, acc} pair shifts right by one, then
// every BCD nibble that is 8 or more has 3 subtracted.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset       asynchronous, active-high; clears all state
//   write       Avalon write strobe (ignored while a conversion is running)
//   write_data  packed BCD, digit 0 in [3:0]
//   read        Avalon read strobe, zero wait states, no side effects
//   read_data   {busy, error, binary[13:0]} while read is high, else 0
//   binary      last conversion result
//   valid       one-cycle pulse when binary/error are updated
//   busy        conversion in progress
//   error       last accepted write contained a digit > 9
// ---------------------------------------------------------------------------
module bcd_to_binary_avalon #(
    parameter int DIGITS = 4,
    parameter int BITS   = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [4*DIGITS-1:0]   write_data,
    input  logic                  read,
    output logic [15:0]           read_data,
    output logic [BITS-1:0]       binary,
    output logic                  valid,
    output logic                  busy,
    output logic                  error
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]      state_q,  state_d;
    logic [BW-1:0]   bcd_q,    bcd_d;
    logic [BITS-1:0] acc_q,    acc_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [BITS-1:0] binary_q, binary_d;
    logic            error_q,  error_d;
    logic            busy_q,   busy_d;

    logic            bad_digit;
    logic [BW-1:0]   bcd_shift;
    logic [BW-1:0]   bcd_fix;
    logic [BITS-1:0] acc_shift;
    logic [3:0]      nib;
    logic [13:0]     bin_field;

    // Any nibble above 9 makes the whole write an error.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (write_data[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    // One reverse double-dabble step: shift right, then correct all nibbles
    // of the shifted bcd in parallel.
    always_comb begin
        bcd_shift = {1'b0, bcd_q[BW-1:1]};
        acc_shift = {bcd_q[0], acc_q[BITS-1:1]};
        bcd_fix   = bcd_shift;
        nib       = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = bcd_shift[4*i +: 4];
            if (nib >= 4'd8) bcd_fix[4*i +: 4] = nib - 4'd3;
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        bcd_d    = bcd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        error_d  = error_q;
        busy_d   = busy_q;

        case (state_q)
            // DONE accepts a write exactly like IDLE for back-to-back use.
            IDLE, DONE: begin
                state_d = IDLE;
                if (write) begin
                    if (bad_digit) begin
                        error_d  = 1'b1;
                        binary_d = '0;
                        state_d  = DONE;
                    end else begin
                        error_d = 1'b0;
                        busy_d  = 1'b1;
                        bcd_d   = write_data;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
            end
            // Writes arriving here are dropped; the CPU polls busy.
            SHIFT: begin
                bcd_d = bcd_fix;
                acc_d = acc_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    binary_d = acc_shift;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bcd_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            binary_q <= '0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
            error_q  <= error_d;
            busy_q   <= busy_d;
        end
    end

    // Fit the result into the 14-bit read field.
    generate
        if (BITS >= 14) begin : g_trunc
            assign bin_field = binary_q[13:0];
        end else begin : g_ext
            assign bin_field = {{(14 - BITS){1'b0}}, binary_q};
        end
    endgenerate

    // valid is decoded from state so a reset mid-conversion can never pulse it.
    assign valid     = (state_q == DONE);
    assign binary    = binary_q;
    assign busy      = busy_q;
    assign error     = error_q;
    assign read_data = read ? {busy_q, error_q, bin_field} : 16'h0000;

endmodule

// File: tb/tb_bcd_to_binary_avalon.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_binary_avalon
//
// Table-driven bench for bcd_to_binary_avalon: each vector writes a BCD word
// and checks latency, busy duration, result, error flag and read_data. Hand
// sequences cover the ignored write, reset mid-conversion and back-to-back
// writes in the DONE cycle.
// ---------------------------------------------------------------------------
module tb_bcd_to_binary_avalon;

    logic        clk;
    logic        reset;
    logic        write;
    logic [15:0] write_data;
    logic        read;
    logic [15:0] read_data;
    logic [13:0] binary;
    logic        valid;
    logic        busy;
    logic        error;

    int checks   = 0;
    int failures = 0;

    bcd_to_binary_avalon #(.DIGITS(4), .BITS(14)) dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .write_data (write_data),
        .read       (read),
        .read_data  (read_data),
        .binary     (binary),
        .valid      (valid),
        .busy       (busy),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] bin;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present a write for exactly one rising edge (E0), starting now.
    task automatic do_write(input logic [15:0] data);
        write      = 1'b1;
        write_data = data;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    // Called just after an edge; counts edges until valid is seen at a
    // falling edge and checks the outputs in that valid cycle. Returns at
    // the falling edge inside the valid cycle.
    task automatic wait_valid(input string name, input int exp_edges,
                              input logic [13:0] exp_bin, input logic exp_err);
        int edges;
        int busy_cnt;
        bit found;
        edges    = 0;
        busy_cnt = 0;
        found    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) begin
                found = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(posedge clk);
            edges++;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s timeout: no valid within 40 cycles", name);
        end else begin
            check({name, " latency"},   edges,     exp_edges);
            check({name, " busy_len"},  busy_cnt,  exp_edges);
            check({name, " binary"},    binary,    exp_bin);
            check({name, " error"},     error,     exp_err);
            check({name, " busy_done"}, busy,      1'b0);
            check({name, " read_data"}, read_data, {1'b0, exp_err, exp_bin});
        end
    endtask

    // Valid must stay low for n consecutive cycles.
    task automatic check_no_valid(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid) seen++;
        end
        check({name, " no_extra_valid"}, seen, 0);
    endtask

    initial begin
        vecs[0] = '{16'h0000, 14'd0,    1'b0};
        vecs[1] = '{16'h9999, 14'd9999, 1'b0};
        vecs[2] = '{16'h1234, 14'd1234, 1'b0};
        vecs[3] = '{16'h12A4, 14'd0,    1'b1};
        vecs[4] = '{16'h0042, 14'd42,   1'b0};
        vecs[5] = '{16'h5000, 14'd5000, 1'b0};
        vecs[6] = '{16'h000F, 14'd0,    1'b1};
        vecs[7] = '{16'h0009, 14'd9,    1'b0};
        vecs[8] = '{16'h0100, 14'd100,  1'b0};
        vecs[9] = '{16'h8765, 14'd8765, 1'b0};

        reset      = 1'b1;
        write      = 1'b0;
        write_data = 16'h0000;
        read       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("reset binary",    binary,    14'd0);
        check("reset valid",     valid,     1'b0);
        check("reset busy",      busy,      1'b0);
        check("reset error",     error,     1'b0);
        check("reset read_data", read_data, 16'h0000);

        // Table vectors.
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            do_write(vecs[v].bcd);
            wait_valid($sformatf("vec%0d", v), vecs[v].err ? 0 : 14,
                       vecs[v].bin, vecs[v].err);
            check_no_valid($sformatf("vec%0d", v), 2);
        end

        // Write while busy is dropped; read mid-conversion shows old result.
        @(negedge clk);
        do_write(16'h1234);             // E0
        repeat (2) @(posedge clk);      // E2
        @(negedge clk);
        check("mid read_data", read_data, {2'b10, 14'd8765});
        @(posedge clk);                 // E3
        @(posedge clk);                 // E4
        @(negedge clk);
        do_write(16'h5678);             // E5, ignored
        wait_valid("ignored_write", 9, 14'd1234, 1'b0);
        check_no_valid("ignored_write", 20);

        // Reset in the middle of a conversion.
        @(negedge clk);
        do_write(16'h0042);             // E0
        repeat (6) @(posedge clk);      // E6
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst binary", binary, 14'd0);
        check("async_rst busy",   busy,   1'b0);
        check("async_rst valid",  valid,  1'b0);
        check("async_rst error",  error,  1'b0);
        @(negedge clk);
        reset = 1'b0;
        check_no_valid("after_reset", 20);
        @(negedge clk);
        do_write(16'h0042);
        wait_valid("post_reset", 14, 14'd42, 1'b0);
        check_no_valid("post_reset", 2);

        // Back-to-back: second write lands in the DONE cycle.
        @(negedge clk);
        do_write(16'h0001);
        wait_valid("b2b_first", 14, 14'd1, 1'b0);
        do_write(16'h0010);             // issued from the DONE cycle
        wait_valid("b2b_second", 14, 14'd10, 1'b0);
        check_no_valid("b2b", 3);

        // An error after a good result clears binary.
        @(negedge clk);
        do_write(16'hF000);
        wait_valid("err_clear", 0, 14'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
